signal_phase_sched: RTL and testbench

//  Demand-adaptive phase scheduler for the four-approach intersection.

---
 rtl/signal_phase_sched.sv | 126 ++++++++++++
 tb/tb_signal_phase_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_phase_sched.sv
// Demand-adaptive N/S vs E/W phase scheduler with min/max green, yellow and all-red clearance.
// Lights and remaining-ticks are decoded combinationally from the registered phase state.
module signal_phase_sched #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int GAP       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] q_n,
  input  logic [7:0] q_s,
  input  logic [7:0] q_e,
  input  logic [7:0] q_w,
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic [7:0] remain,
  output logic       green_start,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    G_NS  = 3'd1,
    Y_NS  = 3'd2,
    AR_EW = 3'd3,
    G_EW  = 3'd4,
    Y_EW  = 3'd5
  } state_t;

  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
  localparam logic [7:0] YEL   = 8'(YELLOW_T);
  localparam logic [7:0] AR    = 8'(ALLRED_T);
  localparam logic [9:0] GAP10 = 10'(GAP);

  state_t     state;
  state_t     state_next;
  logic [7:0] sec;
  logic [7:0] s1;
  logic [8:0] d_ns;
  logic [8:0] d_ew;
  logic [8:0] own;
  logic [8:0] opp;
  logic       g_exit;
  logic [7:0] g_remain;

  assign d_ns     = {1'b0, q_n} + {1'b0, q_s};
  assign d_ew     = {1'b0, q_e} + {1'b0, q_w};
  assign s1       = sec + 8'd1;
  assign g_remain = (sec < MAX_G) ? (MAX_G - sec) : 8'd0;
  assign phase    = state;

  // Green ends only once minimum time is served and the other pair is actually waiting.
  always_comb begin
    own = d_ns;
    opp = d_ew;
    if (state == G_EW) begin
      own = d_ew;
      opp = d_ns;
    end
    g_exit = (s1 >= MIN_G) && (opp != 9'd0) &&
             ((own == 9'd0) || ({1'b0, opp} >= ({1'b0, own} + GAP10)) || (s1 >= MAX_G));
  end

  always_comb begin
    state_next = state;
    light_ns   = 2'b00;
    light_ew   = 2'b00;
    remain     = AR - sec;
    case (state)
      AR_NS: begin
        remain = AR - sec;
        if (s1 == AR) state_next = G_NS;
      end
      G_NS: begin
        light_ns = 2'b01;
        remain   = g_remain;
        if (g_exit) state_next = Y_NS;
      end
      Y_NS: begin
        light_ns = 2'b10;
        remain   = YEL - sec;
        if (s1 == YEL) state_next = AR_EW;
      end
      AR_EW: begin
        remain = AR - sec;
        if (s1 == AR) state_next = G_EW;
      end
      G_EW: begin
        light_ew = 2'b01;
        remain   = g_remain;
        if (g_exit) state_next = Y_EW;
      end
      Y_EW: begin
        light_ew = 2'b10;
        remain   = YEL - sec;
        if (s1 == YEL) state_next = AR_NS;
      end
      default: state_next = AR_NS;
    endcase
  end

  // State and sec only move on tick; green_start marks the first clk of a new green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= AR_NS;
      sec         <= 8'd0;
      green_start <= 1'b0;
    end else begin
      green_start <= 1'b0;
      if (tick) begin
        if (state_next != state) begin
          state       <= state_next;
          sec         <= 8'd0;
          green_start <= (state_next == G_NS) || (state_next == G_EW);
        end else if (sec != 8'd255) begin
          sec <= s1;
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_phase_sched.sv
// Directed bench for signal_phase_sched: reset, green rest, handover, max-out, gap rule,
// asynchronous reset mid-yellow and back-to-back ticks.
module tb_signal_phase_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] q_n = 8'd0;
  logic [7:0] q_s = 8'd0;
  logic [7:0] q_e = 8'd0;
  logic [7:0] q_w = 8'd0;
  logic [1:0] light_ns;
  logic [1:0] light_ew;
  logic [7:0] remain;
  logic       green_start;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  signal_phase_sched #(
    .MIN_GREEN(5), .MAX_GREEN(20), .YELLOW_T(3), .ALLRED_T(1), .GAP(10)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .q_n(q_n), .q_s(q_s), .q_e(q_e), .q_w(q_w),
    .light_ns(light_ns), .light_ew(light_ew), .remain(remain),
    .green_start(green_start), .phase(phase)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic do_reset;
    rst  = 1'b1;
    tick = 1'b0;
    q_n = 8'd0; q_s = 8'd0; q_e = 8'd0; q_w = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // one tick every 4 clks; returns at the negedge after the consuming posedge
  task automatic tick_once;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  // the two pairs must never both be non-red
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (light_ns != 2'b00 && light_ew != 2'b00) begin
        bad++;
        $display("FAIL conflict: ns=%b ew=%b required one of them 00", light_ns, light_ew);
      end
    end
  end

  task automatic test_reset;
    do_reset();
    total++;
    if ({light_ns, light_ew} !== 4'b0000) begin
      bad++; $display("FAIL rst_lights: got %b/%b want 00/00", light_ns, light_ew);
    end
    total++;
    if (remain !== 8'd1) begin bad++; $display("FAIL rst_remain: got %0d want 1", remain); end
    total++;
    if (phase !== 3'd0) begin bad++; $display("FAIL rst_phase: got %0d want 0", phase); end
    total++;
    if (green_start !== 1'b0) begin bad++; $display("FAIL rst_gs: got %b want 0", green_start); end
    tick_once();
    total++;
    if (light_ns !== 2'b01) begin bad++; $display("FAIL t1_ns_green: got %b want 01", light_ns); end
    total++;
    if (remain !== 8'd20) begin bad++; $display("FAIL t1_remain: got %0d want 20", remain); end
    total++;
    if (green_start !== 1'b1) begin bad++; $display("FAIL t1_gs_pulse: got %b want 1", green_start); end
    @(negedge clk);
    total++;
    if (green_start !== 1'b0) begin bad++; $display("FAIL t1_gs_drop: got %b want 0", green_start); end
    tick_n(6);
    total++;
    if (light_ns !== 2'b01 || remain !== 8'd14) begin
      bad++; $display("FAIL t1_idle_rest: got %b/%0d want 01/14", light_ns, remain);
    end
  endtask

  task automatic test_rest_green;
    do_reset();
    q_n = 8'd3;
    tick_once();
    for (int k = 1; k <= 60; k++) begin
      tick_once();
      total++;
      if (light_ns !== 2'b01) begin
        bad++; $display("FAIL rest_light k=%0d: got %b want 01", k, light_ns);
      end
      total++;
      if (remain !== ((k < 20) ? 8'(20 - k) : 8'd0)) begin
        bad++; $display("FAIL rest_remain k=%0d: got %0d want %0d", k, remain,
                        (k < 20) ? (20 - k) : 0);
      end
    end
  endtask

  task automatic test_handover;
    do_reset();
    q_e = 8'd4;
    tick_once();
    tick_n(4);
    total++;
    if (light_ns !== 2'b01 || remain !== 8'd16) begin
      bad++; $display("FAIL ho_min_hold: got %b/%0d want 01/16", light_ns, remain);
    end
    tick_once();
    total++;
    if (light_ns !== 2'b10 || remain !== 8'd3) begin
      bad++; $display("FAIL ho_yellow: got %b/%0d want 10/3", light_ns, remain);
    end
    tick_n(2);
    total++;
    if (light_ns !== 2'b10 || remain !== 8'd1) begin
      bad++; $display("FAIL ho_yellow_end: got %b/%0d want 10/1", light_ns, remain);
    end
    tick_once();
    total++;
    if ({light_ns, light_ew} !== 4'b0000 || remain !== 8'd1 || phase !== 3'd3) begin
      bad++; $display("FAIL ho_allred: got %b/%b/%0d/%0d want 00/00/1/3",
                      light_ns, light_ew, remain, phase);
    end
    tick_once();
    total++;
    if (light_ew !== 2'b01 || light_ns !== 2'b00 || green_start !== 1'b1 || remain !== 8'd20) begin
      bad++; $display("FAIL ho_ew_green: got %b/%b gs=%b r=%0d want 00/01 gs=1 r=20",
                      light_ns, light_ew, green_start, remain);
    end
  endtask

  task automatic test_max_out;
    do_reset();
    q_n = 8'd8; q_w = 8'd1;
    tick_once();
    tick_n(19);
    total++;
    if (light_ns !== 2'b01 || remain !== 8'd1) begin
      bad++; $display("FAIL max_tick19: got %b/%0d want 01/1", light_ns, remain);
    end
    tick_once();
    total++;
    if (light_ns !== 2'b10 || remain !== 8'd3) begin
      bad++; $display("FAIL max_tick20: got %b/%0d want 10/3", light_ns, remain);
    end
  endtask

  task automatic test_gap;
    do_reset();
    q_s = 8'd2;
    tick_once();
    tick_n(6);
    total++;
    if (light_ns !== 2'b01 || remain !== 8'd14) begin
      bad++; $display("FAIL gap_sec6: got %b/%0d want 01/14", light_ns, remain);
    end
    q_e = 8'd12;
    tick_once();
    total++;
    if (light_ns !== 2'b10) begin bad++; $display("FAIL gap_12: got %b want 10", light_ns); end

    do_reset();
    q_s = 8'd2;
    tick_once();
    tick_n(6);
    q_e = 8'd11;
    tick_once();
    total++;
    if (light_ns !== 2'b01) begin bad++; $display("FAIL gap_11_early: got %b want 01", light_ns); end
    tick_n(12);
    total++;
    if (light_ns !== 2'b01 || remain !== 8'd1) begin
      bad++; $display("FAIL gap_11_t19: got %b/%0d want 01/1", light_ns, remain);
    end
    tick_once();
    total++;
    if (light_ns !== 2'b10) begin bad++; $display("FAIL gap_11_max: got %b want 10", light_ns); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_ns;
    logic [1:0] exp_ew;
    logic       exp_gs;
    do_reset();
    q_e = 8'd4;
    tick_n(1 + 5 + 3 + 1);
    q_n = 8'd4; q_e = 8'd0;
    tick_n(5);
    total++;
    if (light_ew !== 2'b10 || phase !== 3'd5) begin
      bad++; $display("FAIL b2b_in_yew: got %b/%0d want 10/5", light_ew, phase);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({light_ns, light_ew} !== 4'b0000 || phase !== 3'd0 || remain !== 8'd1 || green_start !== 1'b0) begin
      bad++; $display("FAIL async_rst: got %b/%b ph=%0d r=%0d gs=%b want 00/00 ph=0 r=1 gs=0",
                      light_ns, light_ew, phase, remain, green_start);
    end
    @(negedge clk);
    rst = 1'b0;
    q_n = 8'd0; q_e = 8'd4;
    tick = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      exp_ns = (n <= 5) ? 2'b01 : (n <= 8) ? 2'b10 : 2'b00;
      exp_ew = (n >= 10) ? 2'b01 : 2'b00;
      exp_gs = (n == 1) || (n == 10);
      total++;
      if (light_ns !== exp_ns || light_ew !== exp_ew || green_start !== exp_gs) begin
        bad++; $display("FAIL b2b clk=%0d: got %b/%b gs=%b want %b/%b gs=%b",
                        n, light_ns, light_ew, green_start, exp_ns, exp_ew, exp_gs);
      end
      if (n == 6 || n == 9) begin
        total++;
        if (remain !== ((n == 6) ? 8'd3 : 8'd1)) begin
          bad++; $display("FAIL b2b_remain clk=%0d: got %0d want %0d", n, remain, (n == 6) ? 3 : 1);
        end
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rest_green();
    test_handover();
    test_max_out();
    test_gap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
